sc_ddr_scrubber: RTL and testbench

//  Background memory scrubber for the SC-OBC V1 Versal DDR4 region. Walks [BASE_ADDR, BASE_ADDR+SIZE)
//  in STRIDE-byte reads so the controller's ECC corrects SEU-flipped words. Sits in PL beside the PS

---
 rtl/sc_ddr_scrub_pkg.sv | 18 +
 rtl/sc_scrub_addr_fifo.sv | 56 +++++
 rtl/sc_ddr_scrubber.sv | 171 +++++++++++++++++
 tb/tb_sc_ddr_scrubber.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_ddr_scrub_pkg.sv
// Shared encodings for the DDR scrubber: response classes and controller states.
package sc_ddr_scrub_pkg;

  typedef enum logic [1:0] {
    RSP_OK  = 2'b00,
    RSP_CE  = 2'b01,
    RSP_UE  = 2'b10,
    RSP_BUS = 2'b11
  } rsp_err_e;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DRAIN
  } scrub_state_e;

endpackage

// File: rtl/sc_scrub_addr_fifo.sv
// Small synchronous FIFO holding {last, addr} of each in-flight scrub read so
// in-order responses can be matched back to their address.
module sc_scrub_addr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 41
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic             wr_en;
  logic             rd_en;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign wr_en   = push && (!full || pop);
  assign rd_en   = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= next_ptr(wr_ptr);
      if (rd_en) rd_ptr <= next_ptr(rd_ptr);
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sc_ddr_scrubber.sv
// Background DDR scrubber: walks a region with strided reads and classifies
// the in-order ECC responses into saturating counters.
//
//   state | meaning
//   IDLE  | stopped; waits for en rising edge and checks region config
//   ISSUE | presents the next read while below the outstanding limit
//   WAIT  | inter-request gap of interval cycles
//   DRAIN | no new reads; waits for all responses, then returns to IDLE
module sc_ddr_scrubber
  import sc_ddr_scrub_pkg::*;
#(
  parameter int ADDR_W    = 40,
  parameter int LEN_W     = 32,
  parameter int STRIDE    = 64,
  parameter int CNT_W     = 16,
  parameter int MAX_OUTST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  size,
  input  logic [31:0]       interval,
  input  logic              clr_cnt,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [ADDR_W-1:0] req_addr,
  input  logic              rsp_valid,
  input  logic [1:0]        rsp_err,
  output logic [CNT_W-1:0]  ce_cnt,
  output logic [CNT_W-1:0]  ue_cnt,
  output logic [CNT_W-1:0]  buserr_cnt,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [ADDR_W-1:0] last_ue_addr,
  output logic              ue_irq,
  output logic              busy,
  output logic              cfg_err
);

  localparam int OW = $clog2(MAX_OUTST + 1);

  scrub_state_e      state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  size_q;
  logic [LEN_W-1:0]  offset_q;
  logic [OW-1:0]     outst_q;
  logic [31:0]       timer_q;
  logic              en_d;
  logic              en_rise;
  logic              cfg_bad;
  logic              accept;
  logic              rsp_take;
  logic              last_req;
  logic              fifo_full;
  logic              fifo_empty;
  logic [ADDR_W:0]   head;
  rsp_err_e          err;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  assign en_rise  = en && !en_d;
  assign cfg_bad  = (size < LEN_W'(STRIDE))
                 || ((base_addr & ADDR_W'(STRIDE - 1)) != '0)
                 || ((size & LEN_W'(STRIDE - 1)) != '0);
  assign req_valid = (state_q == ISSUE) && (outst_q < OW'(MAX_OUTST)) && !fifo_full;
  assign accept    = req_valid && req_ready;
  // Responses with nothing in flight (e.g. stale ones after a reset) are dropped.
  assign rsp_take  = rsp_valid && (outst_q != '0) && !fifo_empty;
  assign req_addr  = base_q + ADDR_W'(offset_q);
  assign last_req  = (offset_q == size_q - LEN_W'(STRIDE));
  assign busy      = (state_q != IDLE);
  assign err       = rsp_err_e'(rsp_err);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (en_rise && !cfg_bad) state_d = ISSUE;
      ISSUE: begin
        if (accept) begin
          if (!en)                 state_d = DRAIN;
          else if (interval != '0) state_d = WAIT;
          else                     state_d = ISSUE;
        end else if (!en && !req_valid) begin
          state_d = DRAIN;
        end
      end
      WAIT: begin
        if (!en)                 state_d = DRAIN;
        else if (timer_q == '0)  state_d = ISSUE;
      end
      DRAIN: if (outst_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      en_d     <= 1'b0;
      cfg_err  <= 1'b0;
      base_q   <= '0;
      size_q   <= '0;
      offset_q <= '0;
      timer_q  <= '0;
      outst_q  <= '0;
    end else begin
      state_q <= state_d;
      en_d    <= en;
      // Region is frozen for the whole run; changes only land on the next start.
      if (state_q == IDLE && en_rise) begin
        cfg_err <= cfg_bad;
        base_q  <= base_addr;
        size_q  <= size;
      end
      if (accept) begin
        offset_q <= last_req ? '0 : offset_q + LEN_W'(STRIDE);
        timer_q  <= interval - 32'd1;
      end else if (state_q == WAIT && timer_q != '0) begin
        timer_q <= timer_q - 32'd1;
      end
      if (state_q == DRAIN && state_d == IDLE) offset_q <= '0;
      case ({accept, rsp_take})
        2'b10:   outst_q <= outst_q + 1'b1;
        2'b01:   outst_q <= outst_q - 1'b1;
        default: outst_q <= outst_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ce_cnt       <= '0;
      ue_cnt       <= '0;
      buserr_cnt   <= '0;
      pass_cnt     <= '0;
      last_ue_addr <= '0;
      ue_irq       <= 1'b0;
    end else begin
      ue_irq <= rsp_take && (err == RSP_UE);
      if (rsp_take && err == RSP_UE) last_ue_addr <= head[ADDR_W-1:0];
      if (clr_cnt) begin
        ce_cnt     <= '0;
        ue_cnt     <= '0;
        buserr_cnt <= '0;
        pass_cnt   <= '0;
      end else if (rsp_take) begin
        if (err == RSP_CE)  ce_cnt     <= sat_inc(ce_cnt);
        if (err == RSP_UE)  ue_cnt     <= sat_inc(ue_cnt);
        if (err == RSP_BUS) buserr_cnt <= sat_inc(buserr_cnt);
        if (head[ADDR_W])   pass_cnt   <= sat_inc(pass_cnt);
      end
    end
  end

  sc_scrub_addr_fifo #(
    .DEPTH (MAX_OUTST),
    .WIDTH (ADDR_W + 1)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (accept),
    .pop     (rsp_take),
    .wr_data ({last_req, req_addr}),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_sc_ddr_scrubber.sv
// Scoreboard bench for sc_ddr_scrubber: directed runs push expected requests and
// counter snapshots; monitors compare whenever the DUT handshakes or updates.
module tb_sc_ddr_scrubber;

  localparam int ADDR_W = 40;
  localparam int LEN_W  = 32;
  localparam int CNT_W  = 4;   // narrow counters so saturation is reachable quickly

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              last;
  } req_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [LEN_W-1:0]  size = '0;
  logic [31:0]       interval = '0;
  logic              clr_cnt = 1'b0;
  logic              req_valid;
  logic              req_ready = 1'b0;
  logic [ADDR_W-1:0] req_addr;
  logic              rsp_valid = 1'b0;
  logic [1:0]        rsp_err = 2'b00;
  logic [CNT_W-1:0]  ce_cnt, ue_cnt, buserr_cnt, pass_cnt;
  logic [ADDR_W-1:0] last_ue_addr;
  logic              ue_irq, busy, cfg_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int hs_count = 0;
  int irq_cnt  = 0;
  int ovf_cnt  = 0;
  int rsp_budget = 0;
  bit stray_req = 0;
  bit clr_with_next = 0;
  bit prev_rsp = 0;

  req_t                 exp_req_q[$];
  req_t                 inflight_q[$];
  logic [1:0]           rsp_err_q[$];
  logic [ADDR_W-1:0]    exp_ue_q[$];
  logic [4*CNT_W-1:0]   exp_cnt_q[$];
  int                   hs_cyc[$];
  logic [CNT_W-1:0]     m_ce = '0, m_ue = '0, m_bus = '0, m_pass = '0;

  sc_ddr_scrubber #(
    .ADDR_W(ADDR_W), .LEN_W(LEN_W), .STRIDE(64), .CNT_W(CNT_W), .MAX_OUTST(4)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .base_addr(base_addr), .size(size),
    .interval(interval), .clr_cnt(clr_cnt), .req_valid(req_valid),
    .req_ready(req_ready), .req_addr(req_addr), .rsp_valid(rsp_valid),
    .rsp_err(rsp_err), .ce_cnt(ce_cnt), .ue_cnt(ue_cnt), .buserr_cnt(buserr_cnt),
    .pass_cnt(pass_cnt), .last_ue_addr(last_ue_addr), .ue_irq(ue_irq),
    .busy(busy), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Request monitor: every accepted read must match the next expected address.
  always @(negedge clk) begin
    if (!rst && req_valid && req_ready) begin
      hs_count++;
      hs_cyc.push_back(cyc);
      if (exp_req_q.size() == 0) begin
        check("req_unexpected", req_addr, 64'hDEAD);
      end else begin
        req_t e;
        e = exp_req_q.pop_front();
        check("req_addr", req_addr, e.addr);
        inflight_q.push_back(e);
      end
    end
  end

  // Counter monitor: one cycle after each driven response the counters must match.
  always @(negedge clk) begin
    if (rst) begin
      prev_rsp = 0;
    end else begin
      if (prev_rsp) begin
        if (exp_cnt_q.size() == 0) check("cnt_unexpected", 64'h1, 64'h0);
        else check("counters", {ce_cnt, ue_cnt, buserr_cnt, pass_cnt}, exp_cnt_q.pop_front());
      end
      prev_rsp = rsp_valid;
    end
  end

  // UE interrupt monitor.
  always @(negedge clk) begin
    if (!rst && ue_irq) begin
      irq_cnt++;
      if (exp_ue_q.size() == 0) check("ue_irq_unexpected", 64'h1, 64'h0);
      else check("last_ue_addr", last_ue_addr, exp_ue_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!rst && ((dut.u_fifo.push && dut.u_fifo.full && !dut.u_fifo.pop) ||
                 (dut.u_fifo.pop && dut.u_fifo.empty)))
      ovf_cnt++;
  end

  // Responder: answers in-flight reads (limited by rsp_budget, -1 = unlimited).
  initial begin
    forever begin
      @(posedge clk);
      #2;
      rsp_valid = 1'b0;
      rsp_err   = 2'b00;
      clr_cnt   = 1'b0;
      if (!rst) begin
        if (stray_req) begin
          stray_req = 0;
          rsp_valid = 1'b1;
          rsp_err   = 2'b01;
          exp_cnt_q.push_back({m_ce, m_ue, m_bus, m_pass});
        end else if (inflight_q.size() > 0 && rsp_budget != 0) begin
          req_t e;
          logic [1:0] er;
          e  = inflight_q.pop_front();
          er = (rsp_err_q.size() > 0) ? rsp_err_q.pop_front() : 2'b00;
          rsp_valid = 1'b1;
          rsp_err   = er;
          case (er)
            2'b01: m_ce = sat(m_ce);
            2'b10: begin m_ue = sat(m_ue); exp_ue_q.push_back(e.addr); end
            2'b11: m_bus = sat(m_bus);
            default: ;
          endcase
          if (e.last) m_pass = sat(m_pass);
          if (clr_with_next) begin
            clr_with_next = 0;
            clr_cnt = 1'b1;
            m_ce = '0; m_ue = '0; m_bus = '0; m_pass = '0;
          end
          exp_cnt_q.push_back({m_ce, m_ue, m_bus, m_pass});
          if (rsp_budget > 0) rsp_budget--;
        end
      end
    end
  end

  task automatic apply_reset();
    rst = 1'b1; en = 1'b0; req_ready = 1'b0; rsp_budget = 0;
    stray_req = 0; clr_with_next = 0;
    tick(2);
    exp_req_q.delete(); inflight_q.delete(); rsp_err_q.delete();
    exp_ue_q.delete(); exp_cnt_q.delete(); hs_cyc.delete();
    m_ce = '0; m_ue = '0; m_bus = '0; m_pass = '0;
    hs_count = 0; irq_cnt = 0;
    rst = 1'b0;
    tick(1);
  endtask

  task automatic start(input logic [ADDR_W-1:0] b, input logic [LEN_W-1:0] s, input logic [31:0] iv);
    base_addr = b; size = s; interval = iv; en = 1'b1;
    tick(1);
  endtask

  task automatic wait_hs(input int n, input string name);
    int t = 0;
    while (hs_count < n && t < 500) begin tick(1); t++; end
    check(name, hs_count, n);
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while (busy && t < 300) begin tick(1); t++; end
    check(name, busy, 0);
  endtask

  task automatic push_reqs(input logic [ADDR_W-1:0] b, input int n, input int per_pass);
    for (int i = 0; i < n; i++) begin
      req_t e;
      e.addr = b + ADDR_W'((i % per_pass) * 64);
      e.last = ((i % per_pass) == per_pass - 1);
      exp_req_q.push_back(e);
    end
  endtask

  initial begin
    // 1: reset values, then continuous walk with wrap
    apply_reset();
    check("rst_req_valid", req_valid, 0);
    check("rst_req_addr", req_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_counters", {ce_cnt, ue_cnt, buserr_cnt, pass_cnt}, 0);
    check("rst_last_ue", last_ue_addr, 0);
    check("rst_irq_cfg", {ue_irq, cfg_err}, 0);
    push_reqs(40'h1000, 12, 4);
    req_ready = 1'b1; rsp_budget = -1;
    start(40'h1000, 32'h100, 0);
    wait_hs(8, "t1_handshakes");
    en = 1'b0;
    wait_idle("t1_idle");
    check("t1_pass_cnt", pass_cnt, 2);

    // 2: interval spacing
    apply_reset();
    push_reqs(40'h2000, 3, 4);
    req_ready = 1'b1; rsp_budget = -1;
    start(40'h2000, 32'h100, 5);
    wait_hs(3, "t2_handshakes");
    en = 1'b0;
    wait_idle("t2_idle");
    if (hs_cyc.size() >= 3) begin
      check("t2_gap0", hs_cyc[1] - hs_cyc[0], 6);
      check("t2_gap1", hs_cyc[2] - hs_cyc[1], 6);
    end

    // 3: outstanding limit, then reset mid-burst
    apply_reset();
    push_reqs(40'h3000, 5, 16);
    req_ready = 1'b1; rsp_budget = 0;
    start(40'h3000, 32'h400, 0);
    wait_hs(4, "t3_four_accepts");
    tick(4);
    check("t3_valid_low_at_limit", req_valid, 0);
    check("t3_no_fifth_yet", hs_count, 4);
    rsp_budget = 1;
    wait_hs(5, "t3_fifth_after_rsp");
    tick(1);
    apply_reset();
    check("t3_busy_after_rst", busy, 0);
    stray_req = 1;
    tick(4);
    check("t3_valid_after_rst", req_valid, 0);

    // 4: error classification
    apply_reset();
    push_reqs(40'h4000, 4, 4);
    rsp_err_q = '{2'b01, 2'b10, 2'b11, 2'b10};
    req_ready = 1'b1; rsp_budget = -1;
    start(40'h4000, 32'h100, 3);
    wait_hs(4, "t4_handshakes");
    en = 1'b0;
    wait_idle("t4_idle");
    tick(2);
    check("t4_ce", ce_cnt, 1);
    check("t4_ue", ue_cnt, 2);
    check("t4_bus", buserr_cnt, 1);
    check("t4_pass", pass_cnt, 1);
    check("t4_last_ue", last_ue_addr, 40'h40C0);
    check("t4_irq_pulses", irq_cnt, 2);

    // 5: en drops while a request is stalled
    apply_reset();
    push_reqs(40'h5000, 1, 4);
    req_ready = 1'b0; rsp_budget = -1;
    start(40'h5000, 32'h100, 0);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t5_hold_valid", req_valid, 1);
      check("t5_hold_addr", req_addr, 40'h5000);
      tick(1);
    end
    req_ready = 1'b1;
    tick(1);
    req_ready = 1'b0;
    check("t5_draining", busy, 1);
    wait_idle("t5_idle");
    check("t5_one_request", hs_count, 1);

    // 6: config errors, saturation, clear priority, stray response
    apply_reset();
    req_ready = 1'b1; rsp_budget = -1;
    start(40'h6000, 32'h20, 0);
    tick(4);
    check("t6_cfg_err_small", cfg_err, 1);
    check("t6_no_req_small", {busy, req_valid}, 0);
    en = 1'b0; tick(2);
    start(40'h6010, 32'h100, 0);
    tick(4);
    check("t6_cfg_err_align", cfg_err, 1);
    check("t6_no_req_align", hs_count, 0);
    en = 1'b0; tick(2);
    push_reqs(40'h6000, 20, 4);
    for (int i = 0; i < 20; i++) rsp_err_q.push_back(2'b01);
    start(40'h6000, 32'h100, 2);
    check("t6_cfg_err_cleared", cfg_err, 0);
    wait_hs(20, "t6_handshakes");
    en = 1'b0;
    wait_idle("t6_idle");
    tick(2);
    check("t6_ce_saturated", ce_cnt, 15);
    check("t6_pass", pass_cnt, 5);
    stray_req = 1;
    tick(3);
    push_reqs(40'h6000, 2, 4);
    rsp_err_q = '{2'b01, 2'b01};
    clr_with_next = 1;
    start(40'h6000, 32'h100, 2);
    wait_hs(22, "t6_second_run");
    en = 1'b0;
    wait_idle("t6_idle2");
    tick(2);
    check("t6_ce_after_clr", ce_cnt, 1);
    check("t6_pass_after_clr", pass_cnt, 0);

    check("fifo_ovf_unf", ovf_cnt, 0);
    check("ue_queue_drained", exp_ue_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
